// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline hazard types, forwarding encodings and helpers
package pipe_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        MCWAIT = 1'b1
    } hz_state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG   = 2'b00;
    localparam fwd_sel_t FWD_EXMEM = 2'b10;
    localparam fwd_sel_t FWD_MEMWB = 2'b01;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    // True when a source that is actually read names a live, nonzero destination.
    function automatic logic src_hit(
        input logic       uses,
        input logic [4:0] src,
        input logic       writes,
        input logic [4:0] dst
    );
        return uses && writes && (dst != REG_ZERO) && (src == dst);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - ALU operand forwarding select, EX/MEM preferred over MEM/WB
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    logic a_exmem;
    logic a_memwb;
    logic b_exmem;
    logic b_memwb;

    assign a_exmem = src_hit(1'b1, ex_rs, mem_regwrite, mem_rd);
    assign a_memwb = src_hit(1'b1, ex_rs, wb_regwrite, wb_rd);
    assign b_exmem = src_hit(1'b1, ex_rt, mem_regwrite, mem_rd);
    assign b_memwb = src_hit(1'b1, ex_rt, wb_regwrite, wb_rd);

    // The younger result in EX/MEM wins when both stages write the same register.
    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (a_exmem) begin
            fwd_a = FWD_EXMEM;
        end else if (a_memwb) begin
            fwd_a = FWD_MEMWB;
        end
        if (b_exmem) begin
            fwd_b = FWD_EXMEM;
        end else if (b_memwb) begin
            fwd_b = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/forward control; FORWARDING_EN enables forwarding
module hazard_ctrl
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwrite,
    input  logic        ex_memread,
    input  logic [4:0]  mem_rd,
    input  logic        mem_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic        wb_regwrite,
    input  logic        ex_mc_start,
    input  logic [3:0]  ex_mc_cycles,
    input  logic        mem_branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        idex_hold,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cycles
);

    hz_state_t  state;
    hz_state_t  state_next;
    logic [3:0] mc_cnt;
    logic [3:0] mc_cnt_next;
    logic       load_use;
    logic       raw_stall;
    logic       mc_req;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    assign load_use = ex_memread &&
                      (src_hit(id_uses_rs, id_rs, 1'b1, ex_rd) ||
                       src_hit(id_uses_rt, id_rt, 1'b1, ex_rd));

    assign mc_req = ex_mc_start && (ex_mc_cycles >= 4'd2);

`ifdef FORWARDING_EN
    logic unused_fwd_en;

    assign raw_stall     = 1'b0;
    assign unused_fwd_en = ex_regwrite;

    fwd_unit u_fwd_unit (
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd_a        (fwd_a_raw),
        .fwd_b        (fwd_b_raw)
    );
`else
    logic unused_no_fwd;

    // The register file writes before it reads, so only EX and MEM producers stall.
    assign raw_stall = src_hit(id_uses_rs, id_rs, ex_regwrite, ex_rd)   ||
                       src_hit(id_uses_rt, id_rt, ex_regwrite, ex_rd)   ||
                       src_hit(id_uses_rs, id_rs, mem_regwrite, mem_rd) ||
                       src_hit(id_uses_rt, id_rt, mem_regwrite, mem_rd);

    assign fwd_a_raw     = FWD_REG;
    assign fwd_b_raw     = FWD_REG;
    assign unused_no_fwd = ^{ex_rs, ex_rt, wb_rd, wb_regwrite};
`endif

    assign fwd_a = rst ? FWD_REG : fwd_a_raw;
    assign fwd_b = rst ? FWD_REG : fwd_b_raw;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        idex_hold   = 1'b0;
        state_next  = state;
        mc_cnt_next = mc_cnt;

        if (rst) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_next  = RUN;
            mc_cnt_next = 4'd0;
        end else if (mem_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_next  = RUN;
            mc_cnt_next = 4'd0;
        end else if (state == MCWAIT) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_hold   = 1'b1;
            exmem_flush = 1'b1;
            mc_cnt_next = mc_cnt - 4'd1;
            // Leave once the count reaches 1; the start cycle already stalled once.
            if (mc_cnt <= 4'd2) begin
                state_next  = RUN;
                mc_cnt_next = 4'd0;
            end
        end else if (mc_req) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_hold   = 1'b1;
            exmem_flush = 1'b1;
            // A two-cycle op is covered entirely by this cycle's stall.
            if (ex_mc_cycles > 4'd2) begin
                state_next  = MCWAIT;
                mc_cnt_next = ex_mc_cycles - 4'd1;
            end
        end else if (load_use || raw_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            mc_cnt       <= 4'd0;
            stall_cycles <= 16'd0;
        end else begin
            state  <= state_next;
            mc_cnt <= mc_cnt_next;
            if (!pc_write && (stall_cycles != STALL_MAX)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_memread;
    logic [4:0]  mem_rd;
    logic        mem_regwrite;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic        ex_mc_start;
    logic [3:0]  ex_mc_cycles;
    logic        mem_branch_taken;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_flush;
    logic        idex_hold;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [15:0] stall_cycles;

    int          n_cmp;
    int          n_err;
    int          exp_stall;

    hazard_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_uses_rs       (id_uses_rs),
        .id_uses_rt       (id_uses_rt),
        .ex_rs            (ex_rs),
        .ex_rt            (ex_rt),
        .ex_rd            (ex_rd),
        .ex_regwrite      (ex_regwrite),
        .ex_memread       (ex_memread),
        .mem_rd           (mem_rd),
        .mem_regwrite     (mem_regwrite),
        .wb_rd            (wb_rd),
        .wb_regwrite      (wb_regwrite),
        .ex_mc_start      (ex_mc_start),
        .ex_mc_cycles     (ex_mc_cycles),
        .mem_branch_taken (mem_branch_taken),
        .pc_write         (pc_write),
        .ifid_write       (ifid_write),
        .ifid_flush       (ifid_flush),
        .idex_flush       (idex_flush),
        .exmem_flush      (exmem_flush),
        .idex_hold        (idex_hold),
        .fwd_a            (fwd_a),
        .fwd_b            (fwd_b),
        .stall_cycles     (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0;
        ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = 5'd0; mem_regwrite = 1'b0; wb_rd = 5'd0; wb_regwrite = 1'b0;
        ex_mc_start = 1'b0; ex_mc_cycles = 4'd0; mem_branch_taken = 1'b0;
    endtask

    // Check pc_write for the current cycle, account for the expected stall, advance.
    task automatic cyc(input string tag, input logic exp_pc);
        #1;
        check(tag, {31'd0, pc_write}, {31'd0, exp_pc});
        if (!exp_pc) exp_stall++;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_stall = 0;
        idle();
        rst = 1'b1;
        tick();
        tick();

        // Reset-time outputs
        check("rst_pc_write", {31'd0, pc_write}, 32'd1);
        check("rst_ifid_write", {31'd0, ifid_write}, 32'd1);
        check("rst_flushes", {29'd0, ifid_flush, idex_flush, exmem_flush}, 32'd7);
        check("rst_idex_hold", {31'd0, idex_hold}, 32'd0);
        check("rst_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
        rst = 1'b0;
        #1;
        check("idle_stall_cnt", {16'd0, stall_cycles}, 32'd0);
        check("idle_flushes", {28'd0, ifid_flush, idex_flush, exmem_flush, idex_hold}, 32'd0);
        check("idle_ifid_write", {31'd0, ifid_write}, 32'd1);
        tick();

        // Load-use on rs: one stall cycle with an ID/EX bubble
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        #1;
        check("lu_idex_flush", {31'd0, idex_flush}, 32'd1);
        check("lu_ifid_write", {31'd0, ifid_write}, 32'd0);
        check("lu_idex_hold", {31'd0, idex_hold}, 32'd0);
        cyc("lu_pc_write", 1'b0);
        idle();
        cyc("lu_after_pc_write", 1'b1);
        check("lu_stall_cnt", {16'd0, stall_cycles}, exp_stall);

        // Register 0 and unread sources never stall
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        cyc("lu_r0_pc_write", 1'b1);
        ex_rd = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b0;
        cyc("lu_unused_rs_pc_write", 1'b1);
        id_rs = 5'd0; id_rt = 5'd9; id_uses_rt = 1'b1;
        cyc("lu_rt_pc_write", 1'b1 ^ 1'b1);
        idle();

        // Multi-cycle op of 4 cycles -> 3 stall cycles, then RUN
        ex_mc_start = 1'b1; ex_mc_cycles = 4'd4;
        #1;
        check("mc4_c1_hold", {30'd0, idex_hold, exmem_flush}, 32'd3);
        cyc("mc4_c1_pc_write", 1'b0);
        ex_mc_start = 1'b0;
        #1;
        check("mc4_c2_hold", {30'd0, idex_hold, exmem_flush}, 32'd3);
        cyc("mc4_c2_pc_write", 1'b0);
        check("mc4_c3_hold", {30'd0, idex_hold, exmem_flush}, 32'd3);
        cyc("mc4_c3_pc_write", 1'b0);
        check("mc4_done_hold", {30'd0, idex_hold, exmem_flush}, 32'd0);
        cyc("mc4_done_pc_write", 1'b1);
        check("mc4_stall_cnt", {16'd0, stall_cycles}, exp_stall);

        // Short multi-cycle ops
        ex_mc_start = 1'b1; ex_mc_cycles = 4'd1;
        cyc("mc1_pc_write", 1'b1);
        ex_mc_cycles = 4'd0;
        cyc("mc0_pc_write", 1'b1);
        ex_mc_cycles = 4'd2;
        cyc("mc2_c1_pc_write", 1'b0);
        ex_mc_start = 1'b0;
        cyc("mc2_done_pc_write", 1'b1);

        // Taken branch in the second stall cycle aborts the wait
        ex_mc_start = 1'b1; ex_mc_cycles = 4'd6;
        cyc("br_c1_pc_write", 1'b0);
        ex_mc_start = 1'b0; mem_branch_taken = 1'b1;
        #1;
        check("br_flushes", {29'd0, ifid_flush, idex_flush, exmem_flush}, 32'd7);
        check("br_idex_hold", {31'd0, idex_hold}, 32'd0);
        cyc("br_c2_pc_write", 1'b1);
        mem_branch_taken = 1'b0;
        #1;
        check("br_run_hold", {31'd0, idex_hold}, 32'd0);
        cyc("br_run_pc_write", 1'b1);
        check("br_stall_cnt", {16'd0, stall_cycles}, exp_stall);

        // Forwarding selection
        ex_rs = 5'd7; ex_rt = 5'd0; mem_rd = 5'd7; wb_rd = 5'd7;
        mem_regwrite = 1'b1; wb_regwrite = 1'b1;
        #1;
`ifdef FORWARDING_EN
        check("fwd_a_exmem_pri", {30'd0, fwd_a}, 32'd2);
        check("fwd_b_none", {30'd0, fwd_b}, 32'd0);
        mem_regwrite = 1'b0;
        #1;
        check("fwd_a_memwb", {30'd0, fwd_a}, 32'd1);
        ex_rt = 5'd0; wb_rd = 5'd0; wb_regwrite = 1'b1;
        #1;
        check("fwd_b_r0", {30'd0, fwd_b}, 32'd0);
        check("fwd_a_wb_r0", {30'd0, fwd_a}, 32'd0);
`else
        check("nofwd_a", {30'd0, fwd_a}, 32'd0);
        check("nofwd_b", {30'd0, fwd_b}, 32'd0);
`endif
        tick();
        idle();

        // ALU result consumed by the next instruction (rt)
        ex_regwrite = 1'b1; ex_rd = 5'd3; id_rt = 5'd3; id_uses_rt = 1'b1;
`ifdef FORWARDING_EN
        cyc("raw_c1_pc_write", 1'b1);
        ex_regwrite = 1'b0; ex_rd = 5'd0; mem_regwrite = 1'b1; mem_rd = 5'd3;
        cyc("raw_c2_pc_write", 1'b1);
`else
        #1;
        check("raw_c1_idex_flush", {31'd0, idex_flush}, 32'd1);
        cyc("raw_c1_pc_write", 1'b0);
        ex_regwrite = 1'b0; ex_rd = 5'd0; mem_regwrite = 1'b1; mem_rd = 5'd3;
        cyc("raw_c2_pc_write", 1'b0);
`endif
        mem_regwrite = 1'b0; mem_rd = 5'd0; wb_regwrite = 1'b1; wb_rd = 5'd3;
        cyc("raw_c3_pc_write", 1'b1);
        check("raw_stall_cnt", {16'd0, stall_cycles}, exp_stall);
        idle();

        // Saturation of the stall counter
        ex_memread = 1'b1; ex_rd = 5'd12; id_rs = 5'd12; id_uses_rs = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        check("sat_stall_cnt", {16'd0, stall_cycles}, 32'h0000_FFFF);
        idle();

        // Reset in the middle of a multi-cycle wait
        ex_mc_start = 1'b1; ex_mc_cycles = 4'd8;
        tick();
        ex_mc_start = 1'b0;
        #1;
        check("rstmc_pre_hold", {31'd0, idex_hold}, 32'd1);
        rst = 1'b1;
        #1;
        check("rstmc_pc_write", {31'd0, pc_write}, 32'd1);
        check("rstmc_flushes", {28'd0, ifid_flush, idex_flush, exmem_flush, idex_hold}, 32'd14);
        tick();
        rst = 1'b0;
        #1;
        check("rstmc_stall_cnt", {16'd0, stall_cycles}, 32'd0);
        check("rstmc_run_hold", {31'd0, idex_hold}, 32'd0);
        check("rstmc_run_pc_write", {31'd0, pc_write}, 32'd1);
        tick();
        check("rstmc_after_stall_cnt", {16'd0, stall_cycles}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  in  1  rising-edge clock shared with all pipeline stage registers.
REQ-002 rst  in  1  reset; synchronous and active-high.
REQ-003 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-004 id_uses_rs, id_uses_rt  in  1 each  the ID instruction reads that source.
REQ-005 ex_rs, ex_rt, ex_rd  in  5 each  register numbers in ID/EX; ex_rd is already RegDst-selected.
REQ-006 ex_regwrite, ex_memread  in  1 each  WB/MEM control bits held in ID/EX.
REQ-007 mem_rd, wb_rd  in  5 each; mem_regwrite, wb_regwrite  in  1 each  destination info in EX/MEM and MEM/WB.
REQ-008 ex_mc_start  in  1; ex_mc_cycles  in  4  EX holds a multi-cycle op needing ex_mc_cycles cycles.
REQ-009 mem_branch_taken  in  1  branch in MEM resolved taken.
REQ-010 pc_write, ifid_write  out  1 each  enables for PC and IF/ID.
REQ-011 ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (all control bits 0) into that register.
REQ-012 idex_hold  out  1  ID/EX keeps its contents.
REQ-013 fwd_a, fwd_b  out  2 each  ALU operand source: 00 regfile, 10 EX/MEM, 01 MEM/WB.
REQ-014 stall_cycles  out  16  saturating count of cycles with pc_write=0.

Function
REQ-015 States: RUN, MCWAIT; all stall/flush outputs are combinational from the state and the current inputs.
REQ-016 Priority each cycle: branch flush > multi-cycle wait > load-use > RAW stall (RAW stall only without FORWARDING_EN).
REQ-017 Branch: mem_branch_taken=1 -> ifid_flush=idex_flush=exmem_flush=1, pc_write=1, idex_hold=0; next state RUN (aborts MCWAIT).
REQ-018 RUN, ex_mc_start=1 with ex_mc_cycles>=2 -> next state MCWAIT, counter loaded with ex_mc_cycles-1, and the stall applies in the same cycle; ex_mc_cycles of 0 or 1 -> no stall.
REQ-019 MCWAIT: pc_write=0, ifid_write=0, idex_hold=1, exmem_flush=1; counter decrements each cycle; at counter==1 the next state is RUN, so the total stall is ex_mc_cycles-1 cycles.
REQ-020 Load-use: ex_memread=1, ex_rd!=0, and (id_uses_rs & id_rs==ex_rd or id_uses_rt & id_rt==ex_rd) -> pc_write=0, ifid_write=0, idex_flush=1 for exactly one cycle.
REQ-021 Register 0 never causes a hazard or a forward.
REQ-022 No hazard -> pc_write=ifid_write=1 and all flush/hold outputs 0.
REQ-023 stall_cycles increments each cycle pc_write=0 and holds at 16'hFFFF.

Reset
REQ-024 rst=1 at a clock edge -> state RUN, MC counter 0, stall_cycles 0; this overrides any same-cycle event.
REQ-025 While rst=1: pc_write=ifid_write=1, flushes=1, idex_hold=0, fwd_a=fwd_b=00.
REQ-026 rst asserted during MCWAIT abandons the wait with no residual stall.

Configuration
REQ-027 FORWARDING_EN defined: fwd_a/fwd_b follow REQ-028, and the only data-hazard stall is load-use.
REQ-028 Forwarding: EX/MEM (mem_regwrite, mem_rd==ex_rs/ex_rt, mem_rd!=0) has priority over MEM/WB (wb_regwrite, wb_rd match, wb_rd!=0).
REQ-029 FORWARDING_EN undefined: fwd_a=fwd_b=00 always.
REQ-030 FORWARDING_EN undefined: an ID source matching a nonzero ex_rd with ex_regwrite=1, or mem_rd with mem_regwrite=1, stalls as in REQ-020 until the match clears; the register file writes before it reads, so WB needs no stall.

Structure
REQ-031 The shared package pipe_pkg holds the state enum, the fwd_sel_t encoding constants, and REG_ZERO=5'd0.
REQ-032 Forwarding logic is the sub-module fwd_unit, instantiated only under FORWARDING_EN.

Verification
REQ-033 Load-use: ex_memread=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> one cycle of pc_write=0 and idex_flush=1, then pc_write=1.
REQ-034 Multi-cycle: ex_mc_start=1, ex_mc_cycles=4 -> pc_write=0 for 3 cycles with idex_hold=1 and exmem_flush=1, then RUN; ex_mc_cycles=1 -> no stall.
REQ-035 Branch in MCWAIT: mem_branch_taken=1 in the 2nd stall cycle -> all three flushes=1 and pc_write=1 that cycle, RUN next cycle.
REQ-036 Forwarding (FORWARDING_EN defined): mem_rd=wb_rd=ex_rs=7, both regwrite=1 -> fwd_a=10; ex_rt=0 with wb_rd=0 -> fwd_b=00.
REQ-037 Without FORWARDING_EN: ex_regwrite=1, ex_rd=3, id_rt=3, id_uses_rt=1 -> 2 stall cycles.
REQ-038 Saturation and reset: force 70000 stall cycles -> stall_cycles=16'hFFFF; rst mid-MCWAIT -> RUN and stall_cycles=0 on the next edge.
